// File: rtl/dma_dsc_out_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dma_dsc_out_pkg
// Purpose : Shared types and helpers for the descriptor-out credit channel.
//           Descriptor beat and credit-return structures, credit count width,
//           sink FSM state enum, and credit pack/unpack helpers.
// Revision: 1.0 - initial release
// ============================================================================
package dma_dsc_out_pkg;

    // Credit count field width. It holds counts up to 64, the largest legal
    // buffer depth, so any DEPTH configuration fits without truncation.
    localparam int c_crd_cnt_w  = 7;
    localparam int c_dsc_len_w  = 16;
    localparam int c_dsc_addr_w = 32;

    // Descriptor beat. vld qualifies the beat on the input side and is
    // carried through the buffer unchanged.
    typedef struct packed {
        logic                    vld;
        logic [c_dsc_len_w-1:0]  len;
        logic [c_dsc_addr_w-1:0] addr;
    } dma_dsc_block_t;

    // Credit return beat.
    typedef struct packed {
        logic                   vld;
        logic [c_crd_cnt_w-1:0] count;
    } dma_dsc_out_crd_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2
    } dma_dsc_out_snk_st_e;

    // Idle credit beats carry a zero count so the bus never shows stale data.
    function automatic dma_dsc_out_crd_t dma_dsc_out_crd_pack(
        input logic                   vld,
        input logic [c_crd_cnt_w-1:0] count
    );
        dma_dsc_out_crd_t c;
        c.vld   = vld;
        c.count = vld ? count : '0;
        return c;
    endfunction

    function automatic logic [c_crd_cnt_w-1:0] dma_dsc_out_crd_unpack(
        input dma_dsc_out_crd_t c
    );
        return c.vld ? c.count : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_dsc_out_crd_snk_if.sv
`default_nettype none
// ============================================================================
// Module  : dma_dsc_out_crd_snk_if
// Purpose : Bundle of the descriptor-out sink channel signals.
//   dsc_in  : descriptor beat from source (vld qualifies)
//   crd_out : credit return to source
//   dsc_vld : buffered descriptor available to consumer
//   dsc_rdy : consumer accept
//   dsc_out : head-of-buffer descriptor
//   master  : source/consumer side; slave : the sink
// Revision: 1.0 - initial release
// ============================================================================
interface dma_dsc_out_crd_snk_if;
    import dma_dsc_out_pkg::*;

    dma_dsc_block_t   dsc_in;
    dma_dsc_out_crd_t crd_out;
    logic             dsc_vld;
    logic             dsc_rdy;
    dma_dsc_block_t   dsc_out;

    modport master (
        output dsc_in,
        output dsc_rdy,
        input  crd_out,
        input  dsc_vld,
        input  dsc_out
    );

    modport slave (
        input  dsc_in,
        input  dsc_rdy,
        output crd_out,
        output dsc_vld,
        output dsc_out
    );

endinterface
`default_nettype wire

// File: rtl/dma_dsc_out_fifo.sv
`default_nettype none
// ============================================================================
// Module  : dma_dsc_out_fifo
// Purpose : DEPTH-entry descriptor buffer with a registered head output.
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : write i_wdata at the tail (ignored when full)
//   i_wdata   : descriptor to write
//   i_pop     : advance the head (ignored when empty)
//   o_rdata   : registered head entry, holds when not popping or empty
//   o_rvld    : registered head valid
//   o_full    : count == DEPTH
//   o_empty   : count == 0
//   o_count   : stored entries
// Revision: 1.0 - initial release
// ============================================================================
module dma_dsc_out_fifo
    import dma_dsc_out_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int c_aw  = $clog2(DEPTH),
    localparam int c_cw  = $clog2(DEPTH) + 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           i_push,
    input  dma_dsc_block_t      i_wdata,
    input  wire logic           i_pop,
    output dma_dsc_block_t      o_rdata,
    output logic                o_rvld,
    output logic                o_full,
    output logic                o_empty,
    output logic [c_cw-1:0]     o_count
);

    dma_dsc_block_t  r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    dma_dsc_block_t  r_rdata;
    logic            r_rvld;

    logic            w_push;
    logic            w_pop;
    logic [c_aw-1:0] w_rd_ptr_nxt;
    logic [c_cw-1:0] w_count_nxt;
    logic            w_head_from_in;
    logic            w_load;
    dma_dsc_block_t  w_head_nxt;

    assign w_push = i_push && (r_count != c_cw'(DEPTH));
    assign w_pop  = i_pop  && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + 1'b1) : r_rd_ptr;

    // When the store drains to nothing but the beat being written this cycle,
    // that beat is not in the array yet, so it is bypassed into the head.
    assign w_head_from_in = (r_count == '0) || (w_pop && (r_count == c_cw'(1)));
    assign w_head_nxt     = w_head_from_in ? i_wdata : r_mem[w_rd_ptr_nxt];

    // Head only changes when it is consumed or when it was empty; otherwise
    // it holds so the consumer sees a stable value.
    assign w_load = (w_pop || (r_count == '0)) && (w_count_nxt != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
            r_rvld   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_rvld   <= (w_count_nxt != '0);
            if (w_load) begin
                r_rdata <= w_head_nxt;
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_rvld  = r_rvld;
    assign o_full  = (r_count == c_cw'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/dma_dsc_out_crd_snk.sv
`default_nettype none
// ============================================================================
// Module  : dma_dsc_out_crd_snk
// Purpose : Sink end of the descriptor-out credit channel. Buffers descriptor
//           beats, presents them to the consumer with valid/ready, and returns
//           credits in batches (or after an idle timeout).
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : dsc_in, crd_out, dsc_vld, dsc_rdy, dsc_out
//   err_ovf      : sticky, a beat arrived without an available credit
//   perf_dsc_cnt : accepted beats (DMA_DSC_OUT_CRD_SNK_PERF_EN only)
//   perf_crd_cnt : credits returned incl. initial grant
//                  (DMA_DSC_OUT_CRD_SNK_PERF_EN only)
// Optional feature macro: DMA_DSC_OUT_CRD_SNK_PERF_EN
// Revision: 1.0 - initial release
// ============================================================================
module dma_dsc_out_crd_snk
    import dma_dsc_out_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int CRD_BATCH = 4,
    parameter int CRD_TMO   = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    dma_dsc_out_crd_snk_if.slave  bus,
    output logic                  err_ovf
`ifdef DMA_DSC_OUT_CRD_SNK_PERF_EN
    ,
    output logic [31:0]           perf_dsc_cnt,
    output logic [31:0]           perf_crd_cnt
`endif
);

    localparam int c_cw = $clog2(DEPTH) + 1;
    localparam int c_tw = $clog2(CRD_TMO) + 1;

    localparam logic [c_cw-1:0] c_batch    = c_cw'(CRD_BATCH);
    localparam logic [c_cw-1:0] c_depth    = c_cw'(DEPTH);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(CRD_TMO - 1);

    dma_dsc_out_snk_st_e r_state;
    dma_dsc_out_snk_st_e w_state_nxt;

    logic [c_cw-1:0]  r_pend;
    logic [c_tw-1:0]  r_tmo;
    dma_dsc_out_crd_t r_crd;
    logic             r_err;

    logic [c_cw-1:0]  w_pend_sum;
    logic [c_cw-1:0]  w_pend_nxt;
    logic [c_tw-1:0]  w_tmo_nxt;
    logic             w_crd_vld;
    logic [c_cw-1:0]  w_crd_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_ovf;
    dma_dsc_block_t   w_rdata;
    logic             w_rvld;
    logic             w_full;
    logic             w_empty;
    logic [c_cw-1:0]  w_count;

    // ------------------------------------------------------------------
    // Buffer
    // ------------------------------------------------------------------
    // No credits exist outside RUN, so any beat there is a protocol error.
    // A full buffer rejects the beat even with a same-cycle pop, because the
    // slot being freed has not had its credit returned yet.
    assign w_push = bus.dsc_in.vld && (r_state == RUN) && !w_full;
    assign w_ovf  = bus.dsc_in.vld && ((r_state != RUN) || (w_count == c_depth));
    assign w_pop  = bus.dsc_rdy && !w_empty;

    dma_dsc_out_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (bus.dsc_in),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_rvld  (w_rvld),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.dsc_vld = w_rvld;
    assign bus.dsc_out = w_rdata;

    // ------------------------------------------------------------------
    // FSM and credit batching
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_crd_vld   = 1'b0;
        w_crd_cnt   = '0;
        w_pend_nxt  = r_pend;
        w_tmo_nxt   = r_tmo;
        w_pend_sum  = r_pend + {{(c_cw-1){1'b0}}, w_pop};
        case (r_state)
            INIT: begin
                w_state_nxt = GRANT;
            end
            GRANT: begin
                w_state_nxt = RUN;
                w_crd_vld   = 1'b1;
                w_crd_cnt   = c_depth;
            end
            RUN: begin
                // tmo counts cycles since the oldest pending credit appeared;
                // it never exceeds CRD_TMO-1 because that value forces a flush.
                if ((w_pend_sum >= c_batch) ||
                    ((w_pend_sum != '0) && (r_tmo == c_tmo_last))) begin
                    w_crd_vld  = 1'b1;
                    w_crd_cnt  = w_pend_sum;
                    w_pend_nxt = '0;
                    w_tmo_nxt  = '0;
                end else begin
                    w_pend_nxt = w_pend_sum;
                    w_tmo_nxt  = (w_pend_sum != '0) ? (r_tmo + 1'b1) : '0;
                end
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crd  <= '0;
            r_pend <= '0;
            r_tmo  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_crd  <= dma_dsc_out_crd_pack(w_crd_vld, c_crd_cnt_w'(w_crd_cnt));
            r_pend <= w_pend_nxt;
            r_tmo  <= w_tmo_nxt;
            if (w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.crd_out = r_crd;
    assign err_ovf     = r_err;

    // ------------------------------------------------------------------
    // Optional performance counters (saturating)
    // ------------------------------------------------------------------
`ifdef DMA_DSC_OUT_CRD_SNK_PERF_EN
    logic [31:0] r_perf_dsc;
    logic [31:0] r_perf_crd;
    logic [32:0] w_perf_crd_sum;

    assign w_perf_crd_sum = {1'b0, r_perf_crd} + {{(33-c_cw){1'b0}}, w_crd_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_dsc <= '0;
            r_perf_crd <= '0;
        end else begin
            if (w_push && (r_perf_dsc != '1)) begin
                r_perf_dsc <= r_perf_dsc + 1'b1;
            end
            if (w_crd_vld) begin
                r_perf_crd <= w_perf_crd_sum[32] ? '1 : w_perf_crd_sum[31:0];
            end
        end
    end

    assign perf_dsc_cnt = r_perf_dsc;
    assign perf_crd_cnt = r_perf_crd;
`endif

endmodule
`default_nettype wire
